dmem_io_arbiter: RTL and testbench
==================================

# dmem_io_arbiter

Two-requester sequencer that shares the data memory and the memory-mapped I/O bus between the CPU data port and the UART program loader. It decodes each transaction into a BRAM access or an I/O chip-select strobe, adds the wait cycle needed by the synchronous BRAM, and returns read data with an explicit acknowledge. The CPU stalls on `cpu_stall`. The block sits between the CPU load/store path and the data memory / LED / segment / switch peripherals.

## Interface
- ADDR_W, 14, data-memory word-address width
- IO_BASE, 32'hFFFF_F800, start of I/O region; any address with bits [31:11] equal to IO_BASE[31:11] is I/O
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU transaction request; held until `cpu_ack`
- cpu_we  in  1  1 = store, 0 = load
- cpu_sext  in  1  sign-extend an 8-bit I/O read (lb); 0 = zero-extend (lbu)
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  32  load data; valid while `cpu_ack` is high and held until the next CPU read completes
- cpu_stall  out  1  `cpu_req & ~cpu_ack`
- ld_req  in  1  loader write request; held until `ld_ack`
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader write data
- ld_ack  out  1  one-cycle completion pulse
- ld_err  out  1  pulses with `ld_ack` when `ld_addr` lies in the I/O region
- mem_en, mem_we  out  1  BRAM enable / write enable
- mem_addr  out  ADDR_W  word address, `addr[ADDR_W+1:2]`
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid one cycle after `mem_en`
- io_we  out  1  I/O write strobe
- io_wdata  out  32  I/O write data
- io_rdata  in  8  I/O read data, combinational from the selected device
- cs_sw1, cs_sw2, cs_led, cs_seg16, cs_seg10  out  1  chip selects at F800, F810, F820, F830, F840

## Operation
- States are IDLE, ISSUE, WAIT and DONE. A registered owner bit (CPU or loader) selects the acknowledge target.
- IDLE:
  - Samples `cpu_req` and `ld_req`.
  - If both are high, round-robin picks the requester not granted last. `last_grant` resets to loader, so the CPU wins the first tie.
  - The winner's address, data, we and sext are latched, and the state moves to ISSUE.
- ISSUE:
  - Memory target: `mem_en=1`, and `mem_we` equals the latched we.
  - I/O target: the decoded `cs_*` is high, and `io_we` equals the latched we.
  - A write goes to DONE. A read goes to WAIT.
- WAIT (reads only):
  - The I/O `cs_*` stays high; `mem_en` is low.
  - At the end of WAIT, `cpu_rdata` captures one of:
    - `mem_rdata`,
    - `{24{io_rdata[7]&sext}, io_rdata}`,
    - zero, for an unmapped I/O address.
  - Next state is DONE.
- DONE: the owner's ack pulses, then the state returns to IDLE.
- Loader I/O-region address: no strobe is issued, and DONE pulses `ld_ack` and `ld_err`.
- Unmapped I/O address (in the region but none of the five): writes are dropped, reads return 0, and the ack is normal.
- Memory address bits above ADDR_W+1 are ignored, so addresses wrap.
- All `mem_*`, `io_*` and `cs_*` outputs are 0 outside ISSUE/WAIT. `mem_wdata` and `io_wdata` carry the latched data in ISSUE and are 0 otherwise.

## Timing
- Reset: state is IDLE; every output is 0, including `cpu_rdata`; `last_grant` is loader.
- Asserting reset mid-transaction aborts it. No ack is issued, and any partial strobe ends immediately.
- Outputs are Moore, decoded from registered state, except `cpu_stall`.
- Latency is counted from the IDLE sampling edge, cycle 0:
  - write: ISSUE in cycle 1, ack in cycle 2;
  - read: ISSUE in cycle 1, WAIT in cycle 2, ack in cycle 3.
- A requester must deassert req at the edge that ends its ack cycle. IDLE then samples the low value, so there is no duplicate.
- Back-to-back transactions complete at best one every 3 cycles for writes and 4 for reads. With both requesters continuously active, they alternate strictly.
- A request changing while not in IDLE is ignored.

## Structure
- Package `dmem_io_pkg`: state enum, IO_BASE, five device offsets (0x00, 0x10, 0x20, 0x30, 0x40), owner encoding.
- Sub-module `io_addr_decode`: combinational; maps a 32-bit address to is_io, a one-hot of the five selects, and unmapped.
- The top level holds the FSM, request latches, round-robin bit and read capture.

## Test plan
- CPU store 0x1234_5678 to 0x0000_0010:
  - cycle 1: `mem_en=mem_we=1`, `mem_addr=4`;
  - cycle 2: `cpu_ack`.
- CPU read of 0x0000_0010 with BRAM holding 0x1234_5678 -> `cpu_ack` in cycle 3 with `cpu_rdata=0x1234_5678`.
- CPU read of F800 with `io_rdata=0x85`:
  - sext=1 -> 0xFFFF_FF85;
  - sext=0 -> 0x0000_0085;
  - `cs_sw1` is high in cycles 1–2 only.
- `cpu_req` and `ld_req` rise together after reset -> CPU is served first, loader next. Repeated simultaneous requests alternate CPU, loader, CPU.
- Loader write to F820 -> no `cs_led`, no `mem_en`; `ld_ack` and `ld_err` in cycle 2. A CPU read of unmapped F850 returns 0.
- Reset asserted during WAIT -> all outputs 0 immediately, no ack; a fresh request after release completes normally.

Source files
------------

// File: rtl/dmem_io_pkg.sv
// dmem_io_pkg: shared types and constants for the data-memory / I/O arbiter.
package dmem_io_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [31:0] IO_BASE = 32'hFFFF_F800;
  localparam logic [10:0] OFF_SW1 = 11'h000;
  localparam logic [10:0] OFF_SW2 = 11'h010;
  localparam logic [10:0] OFF_LED = 11'h020;
  localparam logic [10:0] OFF_SEG16 = 11'h030;
  localparam logic [10:0] OFF_SEG10 = 11'h040;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD = 1'b1;
endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode: maps a byte address to I/O-region hit, device one-hot and unmapped flag.
// addr: byte address; is_io: in I/O window; sel: {seg10,seg16,led,sw2,sw1}; unmapped: in window, no device.
module io_addr_decode import dmem_io_pkg::*; #(
  parameter logic [31:0] IO_BASE = dmem_io_pkg::IO_BASE
) (
  input  logic [31:0] addr,
  output logic        is_io,
  output logic [4:0]  sel,
  output logic        unmapped
);
  assign is_io = addr[31:11] == IO_BASE[31:11];
  assign sel = is_io ? {addr[10:0] == OFF_SEG10, addr[10:0] == OFF_SEG16, addr[10:0] == OFF_LED,
                        addr[10:0] == OFF_SW2, addr[10:0] == OFF_SW1} : 5'b0;
  assign unmapped = is_io & ~|sel;
endmodule

// File: rtl/dmem_io_arbiter.sv
// dmem_io_arbiter: round-robin sequencer sharing BRAM and memory-mapped I/O between CPU and loader.
// cpu_*: CPU load/store port with ack and stall; ld_*: loader write port with ack and error;
// mem_*: synchronous BRAM port; io_*/cs_*: I/O write strobe, data and chip selects.
module dmem_io_arbiter import dmem_io_pkg::*; #(
  parameter int          ADDR_W  = 14,
  parameter logic [31:0] IO_BASE = dmem_io_pkg::IO_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_sext,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ack,
  output logic              ld_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              io_we,
  output logic [31:0]       io_wdata,
  input  logic [7:0]        io_rdata,
  output logic              cs_sw1,
  output logic              cs_sw2,
  output logic              cs_led,
  output logic              cs_seg16,
  output logic              cs_seg10
);
  state_t state, state_nx;
  logic owner, last_grant, a_we, a_sext, grant_ld, is_io, unmapped, issue, io_live;
  logic [31:0] a_addr, a_wdata;
  logic [4:0] sel;
  io_addr_decode #(.IO_BASE(IO_BASE)) u_dec (.addr(a_addr), .is_io(is_io), .sel(sel), .unmapped(unmapped));
  // On a tie the loader wins only if the CPU was granted last.
  assign grant_ld = ld_req & (~cpu_req | last_grant == OWN_CPU);
  assign cpu_stall = cpu_req & ~cpu_ack;
  // Loader accesses to the I/O window are refused: no strobes, error on ack.
  assign io_live = is_io & owner == OWN_CPU;
  assign issue = state == ISSUE;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = (cpu_req | ld_req) ? ISSUE : IDLE;
      ISSUE:   state_nx = a_we ? DONE : WAIT;
      WAIT:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    mem_en = issue & ~is_io;
    mem_we = issue & ~is_io & a_we;
    mem_addr = issue ? a_addr[ADDR_W+1:2] : '0;
    mem_wdata = issue ? a_wdata : '0;
    io_we = issue & io_live & ~unmapped & a_we;
    io_wdata = issue ? a_wdata : '0;
    {cs_seg10, cs_seg16, cs_led, cs_sw2, cs_sw1} = ((issue | state == WAIT) & io_live) ? sel : 5'b0;
    cpu_ack = state == DONE & owner == OWN_CPU;
    ld_ack = state == DONE & owner == OWN_LD;
    ld_err = state == DONE & owner == OWN_LD & is_io;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= OWN_CPU;
      last_grant <= OWN_LD;
      a_we <= 1'b0;
      a_sext <= 1'b0;
      a_addr <= '0;
      a_wdata <= '0;
      cpu_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (cpu_req | ld_req)) begin
        owner <= grant_ld;
        last_grant <= grant_ld;
        a_addr <= grant_ld ? ld_addr : cpu_addr;
        a_wdata <= grant_ld ? ld_wdata : cpu_wdata;
        a_we <= grant_ld | cpu_we;
        a_sext <= ~grant_ld & cpu_sext;
      end
      if (state == WAIT)
        cpu_rdata <= ~is_io ? mem_rdata : unmapped ? '0 : {{24{io_rdata[7] & a_sext}}, io_rdata};
    end
endmodule

// File: tb/tb_dmem_io_arbiter.sv
// tb_dmem_io_arbiter: table-driven directed bench for dmem_io_arbiter with a small BRAM model.
module tb_dmem_io_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic cpu_req = 0, cpu_we = 0, cpu_sext = 0, ld_req = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ld_addr = 0, ld_wdata = 0, mem_rdata, io_wdata, mem_wdata, cpu_rdata;
  logic [7:0] io_rdata = 0;
  logic cpu_ack, cpu_stall, ld_ack, ld_err, mem_en, mem_we, io_we;
  logic cs_sw1, cs_sw2, cs_led, cs_seg16, cs_seg10;
  logic [13:0] mem_addr;
  logic [31:0] bram [16];
  int checks = 0, errors = 0;
  int ack_c [2];
  int order [$];
  logic [31:0] rd;
  logic [63:0] memen_m, cs_m, iowe_m, lderr_m;
  logic [4:0] cs_u;
  logic [13:0] maddr;
  logic stall_bad;

  always #5 clk = ~clk;

  dmem_io_arbiter dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sext(cpu_sext), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_err(ld_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .cs_sw1(cs_sw1), .cs_sw2(cs_sw2), .cs_led(cs_led), .cs_seg16(cs_seg16), .cs_seg10(cs_seg10)
  );

  always @(posedge clk) begin
    if (mem_en && mem_we) bram[mem_addr[3:0]] <= mem_wdata;
    mem_rdata <= bram[mem_addr[3:0]];
  end

  function automatic logic [127:0] outs();
    return {cpu_ack, cpu_rdata, ld_ack, ld_err, mem_en, mem_we, mem_addr, mem_wdata, io_we, io_wdata,
            cs_sw1, cs_sw2, cs_led, cs_seg16, cs_seg10};
  endfunction

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic run(input int nc, input int nl);
    int cl = nc;
    int ll = nl;
    order.delete();
    ack_c = '{-1, -1};
    {memen_m, cs_m, iowe_m, lderr_m} = '0;
    cs_u = 0; maddr = 0; stall_bad = 0; rd = 'x;
    @(posedge clk); #1;
    cpu_req = cl > 0; ld_req = ll > 0;
    for (int c = 0; c < 60 && (cpu_req || ld_req); c++) begin
      @(negedge clk);
      if (mem_en) begin memen_m[c] = 1'b1; maddr = mem_addr; end
      if ({cs_seg10, cs_seg16, cs_led, cs_sw2, cs_sw1} != 0) cs_m[c] = 1'b1;
      cs_u |= {cs_seg10, cs_seg16, cs_led, cs_sw2, cs_sw1};
      if (io_we) iowe_m[c] = 1'b1;
      if (ld_err) lderr_m[c] = 1'b1;
      if (cpu_ack) begin order.push_back(0); ack_c[0] = c; rd = cpu_rdata; stall_bad |= cpu_stall; cl--; end
      if (ld_ack) begin order.push_back(1); ack_c[1] = c; ll--; end
      @(posedge clk); #1;
      cpu_req = cl > 0; ld_req = ll > 0;
    end
    chk("pending_reqs", {cpu_req, ld_req}, 0);
    cpu_req = 0; ld_req = 0;
  endtask

  typedef struct {
    string nm; logic we, sext; logic [31:0] addr, wdata; logic [7:0] io;
    int lat; logic [31:0] rd; logic [4:0] cs; logic [63:0] csm; logic mem; logic [13:0] maddr;
  } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{"st_10",      1, 0, 32'h0000_0010, 32'h1234_5678, 8'h00, 2, 32'h0,         5'b00000, 64'b000, 1, 14'd4};
    tbl[1]  = '{"ld_10",      0, 0, 32'h0000_0010, 32'h0,         8'h00, 3, 32'h1234_5678, 5'b00000, 64'b000, 1, 14'd4};
    tbl[2]  = '{"lb_sw1",     0, 1, 32'hFFFF_F800, 32'h0,         8'h85, 3, 32'hFFFF_FF85, 5'b00001, 64'b110, 0, 14'd0};
    tbl[3]  = '{"lbu_sw1",    0, 0, 32'hFFFF_F800, 32'h0,         8'h85, 3, 32'h0000_0085, 5'b00001, 64'b110, 0, 14'd0};
    tbl[4]  = '{"ld_unmap",   0, 1, 32'hFFFF_F850, 32'h0,         8'hAA, 3, 32'h0,         5'b00000, 64'b000, 0, 14'd0};
    tbl[5]  = '{"st_wrap",    1, 0, 32'h0001_0014, 32'hCAFE_F00D, 8'h00, 2, 32'h0,         5'b00000, 64'b000, 1, 14'd5};
    tbl[6]  = '{"ld_14",      0, 0, 32'h0000_0014, 32'h0,         8'h00, 3, 32'hCAFE_F00D, 5'b00000, 64'b000, 1, 14'd5};
    tbl[7]  = '{"lb_seg16",   0, 1, 32'hFFFF_F830, 32'h0,         8'h7F, 3, 32'h0000_007F, 5'b01000, 64'b110, 0, 14'd0};
    tbl[8]  = '{"lbu_sw2",    0, 0, 32'hFFFF_F810, 32'h0,         8'h80, 3, 32'h0000_0080, 5'b00010, 64'b110, 0, 14'd0};
    tbl[9]  = '{"lb_seg10",   0, 1, 32'hFFFF_F840, 32'h0,         8'hFF, 3, 32'hFFFF_FFFF, 5'b10000, 64'b110, 0, 14'd0};
    tbl[10] = '{"st_led",     1, 0, 32'hFFFF_F820, 32'h0000_00A5, 8'h00, 2, 32'h0,         5'b00100, 64'b010, 0, 14'd0};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), 0);
    chk("reset_stall", cpu_stall, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Simultaneous requests right after reset: CPU, loader, CPU.
    cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h1111_1111;
    ld_addr = 32'h44; ld_wdata = 32'h2222_2222;
    run(2, 1);
    chk("arb_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("arb_first", order[0], 0);
      chk("arb_second", order[1], 1);
      chk("arb_third", order[2], 0);
    end
    chk("arb_ld_cycle", ack_c[1], 5);
    chk("arb_cpu_cycle", ack_c[0], 8);
    chk("arb_no_err", lderr_m, 0);

    foreach (tbl[i]) begin
      cpu_we = tbl[i].we; cpu_sext = tbl[i].sext; cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
      io_rdata = tbl[i].io;
      run(1, 0);
      chk({tbl[i].nm, "_lat"}, ack_c[0], tbl[i].lat);
      chk({tbl[i].nm, "_cs"}, cs_u, tbl[i].cs);
      chk({tbl[i].nm, "_cs_cycles"}, cs_m, tbl[i].csm);
      chk({tbl[i].nm, "_mem_cycles"}, memen_m, tbl[i].mem ? 64'b10 : 64'b0);
      chk({tbl[i].nm, "_io_we"}, iowe_m, (tbl[i].we && tbl[i].cs != 0) ? 64'b10 : 64'b0);
      chk({tbl[i].nm, "_stall_at_ack"}, stall_bad, 0);
      if (tbl[i].mem) chk({tbl[i].nm, "_maddr"}, maddr, tbl[i].maddr);
      if (!tbl[i].we) chk({tbl[i].nm, "_rdata"}, rd, tbl[i].rd);
    end

    // Loader write into the I/O window is refused with an error.
    ld_addr = 32'hFFFF_F820; ld_wdata = 32'h0000_00FF;
    run(0, 1);
    chk("ld_io_lat", ack_c[1], 2);
    chk("ld_io_err", lderr_m, 64'b100);
    chk("ld_io_no_cs", cs_u, 0);
    chk("ld_io_no_mem", memen_m, 0);
    // Loader memory write lands in BRAM.
    ld_addr = 32'h0000_0018; ld_wdata = 32'h5A5A_5A5A;
    run(0, 1);
    chk("ld_mem_lat", ack_c[1], 2);
    chk("ld_mem_no_err", lderr_m, 0);
    chk("ld_mem_cycles", memen_m, 64'b10);
    chk("ld_mem_maddr", maddr, 14'd6);
    cpu_we = 0; cpu_addr = 32'h18;
    run(1, 0);
    chk("ld_readback", rd, 32'h5A5A_5A5A);

    // Reset during the WAIT cycle of an I/O read.
    cpu_we = 0; cpu_sext = 0; cpu_addr = 32'hFFFF_F800; io_rdata = 8'h33;
    @(posedge clk); #1 cpu_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wait_cs_sw1", cs_sw1, 1);
    chk("wait_stall", cpu_stall, 1);
    #1 rst = 1'b1;
    #1 chk("rst_mid_outs", outs(), 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_ack", cpu_ack, 0);
    end
    cpu_req = 0;
    @(posedge clk); #1 rst = 1'b0;
    cpu_addr = 32'h10;
    run(1, 0);
    chk("post_rst_lat", ack_c[0], 3);
    chk("post_rst_rdata", rd, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
